// File: rtl/iir_pkg.sv
// Shared defaults and sample/accumulator types for the IIR output stage.
package iir_pkg;
    localparam int DEF_DW         = 8;
    localparam int DEF_DECIM_LOG2 = 2;
    localparam int DEF_FIFO_AW    = 2;

    typedef logic signed [DEF_DW-1:0]                sample_t;
    typedef logic signed [DEF_DW+DEF_DECIM_LOG2-1:0] acc_t;
endpackage

// File: rtl/iir_decim_fifo_if.sv
// Sample-in / decimated-out stream bundle for iir_decim_fifo.
interface iir_decim_fifo_if #(
    parameter int DW = iir_pkg::DEF_DW
);
    logic                 in_valid;
    logic signed [DW-1:0] x_in;
    logic signed [DW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (output in_valid, x_in, out_ready, input out_data, out_valid);
    modport slave  (input in_valid, x_in, out_ready, output out_data, out_valid);
endinterface

// File: rtl/iir_sync_fifo.sv
// First-word-fall-through FIFO with level output; memory is cleared on reset.
module iir_sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   lvl_q, lvl_d;
    logic          push_ok, pop_ok;

    assign empty_o = (lvl_q == '0);
    assign full_o  = (lvl_q == (AW+1)'(DEPTH));
    assign level_o = lvl_q;
    assign rdata_o = mem_q[rd_q];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        lvl_d = lvl_q;
        if (push_ok && !pop_ok) lvl_d = lvl_q + 1'b1;
        else if (!push_ok && pop_ok) lvl_d = lvl_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_ok) rd_q <= rd_q + 1'b1;
            lvl_q <= lvl_d;
        end
    end
endmodule

// File: rtl/iir_decim_fifo.sv
// Box-car decimator (2^DECIM_LOG2 samples) feeding an FWFT FIFO with sticky overflow.
// Define IIR_DECIM_ROUND_EN for round-half-up averaging; otherwise results are floored.
module iir_decim_fifo
    import iir_pkg::*;
#(
    parameter int DW         = DEF_DW,
    parameter int DECIM_LOG2 = DEF_DECIM_LOG2,
    parameter int FIFO_AW    = DEF_FIFO_AW
) (
    input  logic               clk,
    input  logic               rst,
    iir_decim_fifo_if.slave    bus,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow,
    input  logic               clr_ovf
);
    localparam int AW = DW + DECIM_LOG2;
    localparam logic [DECIM_LOG2-1:0] LAST = '1;
`ifdef IIR_DECIM_ROUND_EN
    localparam logic signed [AW-1:0] RND = AW'(2 ** (DECIM_LOG2 - 1));
`else
    localparam logic signed [AW-1:0] RND = '0;
`endif

    logic signed [AW-1:0]  acc_q, acc_d, sum, rnd_sum;
    logic [DECIM_LOG2-1:0] phase_q, phase_d;
    logic [DW-1:0]         avg;
    logic                  push, pop, full, empty, drop;
    logic                  ovf_q, ovf_d;
    logic                  unused_lsb;

    always_comb begin
        sum     = acc_q + {{DECIM_LOG2{bus.x_in[DW-1]}}, bus.x_in};
        rnd_sum = sum + RND;
        // Arithmetic shift by DECIM_LOG2 then truncation to DW is exactly this slice.
        avg     = rnd_sum[DECIM_LOG2 +: DW];
        push    = bus.in_valid && (phase_q == LAST);
        acc_d   = acc_q;
        phase_d = phase_q;
        if (bus.in_valid) begin
            if (phase_q == LAST) begin
                acc_d   = '0;
                phase_d = '0;
            end else begin
                acc_d   = sum;
                phase_d = phase_q + 1'b1;
            end
        end
    end

    assign unused_lsb = ^rnd_sum[DECIM_LOG2-1:0];

    assign pop   = bus.out_valid & bus.out_ready;
    assign drop  = push & full & ~pop;
    assign ovf_d = drop | (ovf_q & ~clr_ovf);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            phase_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            phase_q <= phase_d;
            ovf_q   <= ovf_d;
        end
    end

    iir_sync_fifo #(.W(DW), .AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (avg),
        .pop_i   (pop),
        .rdata_o (bus.out_data),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level)
    );

    assign bus.out_valid = ~empty;
    assign overflow      = ovf_q;
endmodule

// File: tb/tb_iir_decim_fifo.sv
// Randomized + directed bench for iir_decim_fifo against a queue-based reference model.
module tb_iir_decim_fifo;
    import iir_pkg::*;

    localparam int L     = DEF_DECIM_LOG2;
    localparam int D     = 1 << L;
    localparam int DEPTH = 1 << DEF_FIFO_AW;
`ifdef IIR_DECIM_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 clr_ovf = 1'b0;
    logic [DEF_FIFO_AW:0] fifo_level;
    logic                 overflow;

    iir_decim_fifo_if #(.DW(DEF_DW)) bus ();

    iir_decim_fifo #(.DW(DEF_DW), .DECIM_LOG2(L), .FIFO_AW(DEF_FIFO_AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: running group sum, a queue of stored results, sticky flag.
    int mq[$];
    int gsum, gcnt, mavg;
    bit movf, mpop, mpush;

    function automatic int avg_of(input int s);
        if (ROUND) return (s + D / 2) >>> L;
        return s >>> L;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            gsum = 0;
            gcnt = 0;
            movf = 1'b0;
        end else begin
            mpop  = (mq.size() != 0) && bus.out_ready;
            mpush = 1'b0;
            mavg  = 0;
            if (bus.in_valid) begin
                gsum += int'(bus.x_in);
                gcnt++;
                if (gcnt == D) begin
                    mpush = 1'b1;
                    mavg  = avg_of(gsum);
                    gsum  = 0;
                    gcnt  = 0;
                end
            end
            if (mpush && mq.size() == DEPTH && !mpop) movf = 1'b1;
            else if (clr_ovf) movf = 1'b0;
            if (mpop) void'(mq.pop_front());
            if (mpush && mq.size() < DEPTH) mq.push_back(mavg);
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("out_valid", int'(bus.out_valid), int'(mq.size() != 0));
            chk("fifo_level", int'(fifo_level), mq.size());
            chk("overflow", int'(overflow), int'(movf));
            if (mq.size() != 0) chk("out_data", int'(bus.out_data), mq[0]);
        end
    end

    task automatic drive(input bit v, input int x, input bit rdy);
        @(negedge clk);
        bus.in_valid  = v;
        bus.x_in      = sample_t'(x);
        bus.out_ready = rdy;
    endtask

    task automatic group(input int v, input bit rdy);
        repeat (D) drive(1'b1, v, rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        clr_ovf       = 1'b0;
        #1;
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_data", int'(bus.out_data), 0);
        chk("rst_ovf", int'(overflow), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.x_in      = '0;
        bus.out_ready = 1'b0;

        // Model pins: floor vs round-half-up on a negative sum.
        chk("model_m5", avg_of(-5), ROUND ? -1 : -2);
        chk("model_508", avg_of(508), 127);

        do_reset();
        cmp_en = 1'b1;

        // Constant step: first result one cycle after the 4th sample.
        repeat (D - 1) drive(1'b1, 100, 1'b1);
        drive(1'b1, 100, 1'b1);
        chk("step_not_yet", int'(bus.out_valid), 0);
        drive(1'b0, 0, 1'b1);
        chk("step_valid", int'(bus.out_valid), 1);
        chk("step_data", int'(bus.out_data), 100);
        group(100, 1'b1);
        group(-50, 1'b1);
        drive(1'b0, 0, 1'b1);
        chk("step_neg", int'(bus.out_data), -50);
        drive(1'b0, 0, 1'b1);

        // Rounding and extremes.
        do_reset();
        drive(1'b1, 1, 1'b0); drive(1'b1, 1, 1'b0); drive(1'b1, 1, 1'b0); drive(1'b1, 0, 1'b0);
        drive(1'b1, -1, 1'b0); drive(1'b1, -1, 1'b0); drive(1'b1, -1, 1'b0); drive(1'b1, -2, 1'b0);
        drive(1'b0, 0, 1'b0);
        chk("rnd_level", int'(fifo_level), 2);
        chk("rnd_pos", int'(bus.out_data), ROUND ? 1 : 0);
        drive(1'b0, 0, 1'b1);
        drive(1'b0, 0, 1'b0);
        chk("rnd_neg", int'(bus.out_data), ROUND ? -1 : -2);
        drive(1'b0, 0, 1'b1);
        group(127, 1'b0);
        group(-128, 1'b0);
        drive(1'b0, 0, 1'b0);
        chk("ext_max", int'(bus.out_data), 127);
        drive(1'b0, 0, 1'b1);
        drive(1'b0, 0, 1'b0);
        chk("ext_min", int'(bus.out_data), -128);
        drive(1'b0, 0, 1'b1);

        // Backpressure and overflow.
        do_reset();
        for (int k = 1; k <= 5; k++) group(10 * k, 1'b0);
        drive(1'b0, 0, 1'b0);
        chk("ovf_level", int'(fifo_level), 4);
        chk("ovf_set", int'(overflow), 1);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain", int'(bus.out_data), 10 * k);
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        chk("drain_empty", int'(bus.out_valid), 0);
        chk("ovf_sticky", int'(overflow), 1);
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        chk("ovf_clr", int'(overflow), 0);

        // Full with simultaneous push and pop.
        do_reset();
        for (int k = 1; k <= 4; k++) group(k, 1'b0);
        repeat (D - 1) drive(1'b1, 5, 1'b0);
        drive(1'b1, 5, 1'b1);
        drive(1'b0, 0, 1'b0);
        chk("pp_level", int'(fifo_level), 4);
        chk("pp_ovf", int'(overflow), 0);
        chk("pp_head", int'(bus.out_data), 2);

        // Gaps in in_valid do not split a group.
        do_reset();
        drive(1'b1, 20, 1'b0); drive(1'b0, 99, 1'b0);
        drive(1'b1, 20, 1'b0); drive(1'b0, -99, 1'b0);
        drive(1'b1, 20, 1'b0); drive(1'b0, 7, 1'b0);
        drive(1'b1, 24, 1'b0); drive(1'b0, 0, 1'b0);
        chk("gap_data", int'(bus.out_data), 21);
        chk("gap_level", int'(fifo_level), 1);

        // Reset mid-group discards FIFO contents and the partial sum.
        do_reset();
        group(30, 1'b0);
        drive(1'b1, 100, 1'b0);
        drive(1'b1, 100, 1'b0);
        do_reset();
        group(8, 1'b0);
        drive(1'b0, 0, 1'b0);
        chk("post_rst_data", int'(bus.out_data), 8);
        chk("post_rst_level", int'(fifo_level), 1);

        // Randomized traffic.
        do_reset();
        repeat (800) begin
            @(negedge clk);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.x_in      = sample_t'($urandom);
            bus.out_ready = ($urandom_range(0, 2) == 0);
            clr_ovf       = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        clr_ovf      = 1'b0;
        bus.out_ready = 1'b1;
        repeat (DEPTH + 2) @(negedge clk);
        chk("final_empty", int'(bus.out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/iir_decim_fifo.md
# iir_decim_fifo

Output stage directly downstream of the IIR filter. It consumes the filter's signed 8-bit output stream and box-car averages groups of 2^DECIM_LOG2 samples. Each average is pushed into a small first-word-fall-through FIFO, which is drained by a valid/ready consumer. Dropped results are reported through a sticky overflow flag.

## Interface
- DW, 8, sample width in bits (signed); matches the IIR output width.
- DECIM_LOG2, 2, log2 of the decimation factor D; D=4 by default; legal range 1..6.
- FIFO_AW, 2, log2 of the FIFO depth; depth 4 by default.

Ports:
- clk  in  1  rising-edge clock, shared with the IIR.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  x_in carries a sample this cycle; tie to 1 when the IIR outputs every clock.
- x_in  in  DW  signed sample, connected to the IIR output y.
- out_data  out  DW  signed decimated sample at the FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- fifo_level  out  FIFO_AW+1  current number of stored entries.
- overflow  out  1  sticky: a decimated sample was dropped.
- clr_ovf  in  1  synchronous clear of overflow.

## Operation
- Accumulator acc is signed DW+DECIM_LOG2 bits. phase counts 0..D-1.
- On in_valid with phase<D-1: acc += x_in and phase++.
- On in_valid with phase==D-1:
  - sum = acc + x_in.
  - avg = (sum + RND) >>> DECIM_LOG2, arithmetic shift, where RND is defined under Configuration.
  - avg is taken as the low DW bits; the result always fits, so no saturation logic.
  - avg is pushed; acc is set to 0 and phase to 0.
- When in_valid=0, acc and phase hold. Gaps never split or reset a group.
- FIFO has 2^FIFO_AW entries:
  - pop = out_valid & out_ready.
  - push = group completion.
  - out_data = mem[rd_ptr]; out_valid = (fifo_level != 0).
- Full and push without a pop: avg is dropped, overflow is set, FIFO contents are unchanged.
- Full with push and pop in the same cycle: both succeed, level is unchanged, no overflow.
- Empty with push: entry is written; pop is impossible because out_valid=0.
- Pointers wrap modulo depth. fifo_level ranges 0..2^FIFO_AW.
- overflow: if clr_ovf and a drop event occur in the same cycle, set wins.

## Timing
- Reset values: acc=0, phase=0, pointers=0, fifo_level=0, out_valid=0, out_data=0 (memory cleared), overflow=0.
- Reset asserted mid-group discards the partial sum and the FIFO contents.
- Latency: the last sample of a group is sampled at edge E. With an empty FIFO, out_valid=1 and out_data=avg are visible immediately after E (1 cycle).
- Throughput: one result per D valid input samples.
- A pop at edge E updates out_data and fifo_level after E.
- out_valid/out_data never change while out_valid=1 and out_ready=0, except to become valid from empty.

## Configuration
- IIR_DECIM_ROUND_EN defined: RND = 2^(DECIM_LOG2-1), giving round-half-up. Example: sum -5, D=4 gives -1.
- IIR_DECIM_ROUND_EN undefined: RND = 0, giving floor (arithmetic truncation). Same example gives -2.

## Structure
- Shared package iir_pkg holds:
  - the DW default;
  - typedef sample_t (signed [DW-1:0]);
  - acc_t (signed [DW+DECIM_LOG2-1:0]).
- One natural sub-module, iir_sync_fifo: FWFT, with push/pop/full/empty/level ports. The decimator and overflow logic stay in the top.

## Test plan
- Constant step: x_in=100, in_valid=1, out_ready=1. Outputs are 100 every 4 cycles; the first out_valid appears 1 cycle after the 4th sample. Switching to x_in=-50 gives -50 once a full group is all -50.
- Rounding: groups {1,1,1,0} and {-1,-1,-1,-2}.
  - With IIR_DECIM_ROUND_EN: outputs 1 and -1.
  - Without it: outputs 0 and -2.
- Extremes: groups of all 127 and all -128 give 127 and -128 in both builds.
- Backpressure/overflow: out_ready=0 over 5 groups valued 10,20,30,40,50.
  - fifo_level=4 and overflow=1 after the 5th group.
  - Draining gives 10,20,30,40; 50 is lost.
  - clr_ovf then clears overflow.
- Full with simultaneous push and pop: fill to 4, then raise out_ready for one cycle exactly at a group completion. Level stays 4 and overflow stays 0.
- Gaps and reset: in_valid toggled 1,0,1,0 gives the same averages as contiguous input. Asserting rst after 2 samples of a group restores all reset values, and the next output uses only post-reset samples.
